uart_tx: RTL and testbench

- Parallel-to-serial UART transmitter for the ALU system's UART interface.
- Accepts an 8-bit word with a single-cycle data_valid strobe and emits one frame on tx_out, one bit per clock (no baud divider in this block).
- Frame: start bit, 8 data bits LSB-first, optional parity bit, stop bit.
- Reports frame activity on busy.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_parity_calc.sv | 12 +
 rtl/uart_tx.sv | 114 +++++++++++
 tb/tb_uart_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned CNT_W      = $clog2(DATA_WIDTH);

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

endpackage

// File: rtl/uart_parity_calc.sv
// Frame parity bit: even parity is the XOR of the payload, odd is its complement.
module uart_parity_calc
   import uart_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  parity_c
);

   assign parity_c = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity, stop; one bit per clock.
module uart_tx
   import uart_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy
);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic                   par_en_q, par_en_d;
   logic                   par_typ_q, par_typ_d;
   logic                   tx_out_q, tx_out_d;
   logic                   busy_q, busy_d;
   logic                   parity_c;
   logic                   accept_c;

   uart_parity_calc u_parity (
      .data     (data_q),
      .par_typ  (par_typ_q),
      .parity_c (parity_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         tx_out_q  <= IDLE_LEVEL;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         tx_out_q  <= tx_out_d;
         busy_q    <= busy_d;
      end
   end

   // Outputs are computed for the state being entered, so each bit appears the cycle after its edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      tx_out_d  = IDLE_LEVEL;
      busy_d    = 1'b1;
      accept_c  = data_valid && ((state_q == IDLE) || (state_q == STOP));

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
         end
         START: begin
            state_d  = DATA;
            cnt_d    = '0;
            tx_out_d = data_q[0];
         end
         DATA: begin
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
               if (par_en_q) begin
                  state_d  = PARITY;
                  tx_out_d = parity_c;
               end else begin
                  state_d  = STOP;
                  tx_out_d = STOP_BIT;
               end
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
               tx_out_d = data_q[cnt_q + CNT_W'(1)];
            end
         end
         PARITY: begin
            state_d  = STOP;
            tx_out_d = STOP_BIT;
         end
         STOP: begin
            state_d  = IDLE;
            busy_d   = 1'b0;
         end
         default: begin
            state_d  = IDLE;
            busy_d   = 1'b0;
         end
      endcase

      // Accepting from STOP chains the next start bit directly after the stop bit.
      if (accept_c) begin
         state_d   = START;
         cnt_d     = '0;
         data_d    = p_data;
         par_en_d  = par_en;
         par_typ_d = par_typ;
         tx_out_d  = START_BIT;
         busy_d    = 1'b1;
      end
   end

   assign tx_out = tx_out_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized checks of uart_tx framing, latency, back-to-back and reset behaviour.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic       tx_out;
   logic       busy;

   int errors = 0;
   int checks = 0;

   uart_tx dut (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .tx_out     (tx_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_line(input string name, input int idx,
                              input logic exp_tx, input logic exp_busy);
      checks++;
      if (tx_out !== exp_tx || busy !== exp_busy) begin
         errors++;
         $display("FAIL %s[%0d]: tx_out=%b busy=%b, required tx_out=%b busy=%b",
                  name, idx, tx_out, busy, exp_tx, exp_busy);
      end
   endtask

   // Reference frame built directly from the frame definition.
   task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt,
                              output logic [10:0] bits, output int n);
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
      if (pe) begin
         bits[9]  = pt ? ~(^d) : (^d);
         bits[10] = 1'b1;
         n = 11;
      end else begin
         bits[9] = 1'b1;
         n = 10;
      end
   endtask

   // Called in the start-bit cycle; returns sampled in the stop-bit cycle.
   task automatic check_frame(input string name, input logic [7:0] d,
                              input logic pe, input logic pt);
      logic [10:0] bits;
      int          n;
      build_frame(d, pe, pt, bits, n);
      for (int i = 0; i < n; i++) begin
         if (i > 0) tick();
         expect_line(name, i, bits[i], 1'b1);
      end
   endtask

   task automatic accept(input logic [7:0] d, input logic pe, input logic pt);
      p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
   endtask

   task automatic idle_cycles(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         expect_line(name, i, 1'b1, 1'b0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      data_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         p_data  = 8'($urandom);
         par_en  = 1'($urandom);
         par_typ = 1'($urandom);
         tick();
         expect_line("reset", i, 1'b1, 1'b0);
      end
      data_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 50; i++) begin
         p_data  = 8'($urandom);
         par_en  = 1'($urandom);
         par_typ = 1'($urandom);
         tick();
         expect_line("idle", i, 1'b1, 1'b0);
      end
   endtask

   task automatic test_no_parity();
      logic [9:0] exp_bits;
      int busy_cycles = 0;
      exp_bits = 10'b11_0100_1010; // bit i is the i-th serial bit of 0xA5
      accept(8'hA5, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) begin
         if (i > 0) tick();
         if (busy === 1'b1) busy_cycles++;
         expect_line("no_parity", i, (i < 10) ? exp_bits[i] : 1'b1, (i < 10));
      end
      checks++;
      if (busy_cycles != 10) begin
         errors++;
         $display("FAIL no_parity_busy_len: %0d cycles, required 10", busy_cycles);
      end
   endtask

   task automatic test_parity();
      logic [10:0] even_bits, odd_bits;
      even_bits = 11'b101_0000_0010; // 0x81 even: 0,1,0,0,0,0,0,0,1,0,1
      odd_bits  = 11'b111_0000_0010; // 0x81 odd: parity bit 1
      accept(8'h81, 1'b1, 1'b0);
      for (int i = 0; i < 11; i++) begin
         if (i > 0) tick();
         expect_line("parity_even", i, even_bits[i], 1'b1);
      end
      idle_cycles("parity_even_idle", 2);
      accept(8'h81, 1'b1, 1'b1);
      for (int i = 0; i < 11; i++) begin
         if (i > 0) tick();
         expect_line("parity_odd", i, odd_bits[i], 1'b1);
      end
      idle_cycles("parity_odd_idle", 2);
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       pe, pt;
      int         gap;
      d = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
      accept(d, pe, pt);
      for (int w = 0; w < 400; w++) begin
         check_frame("random", d, pe, pt);
         gap = (w == 399) ? 1 : int'($urandom_range(0, 15));
         d = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
         if (gap == 0) begin
            accept(d, pe, pt);
         end else begin
            idle_cycles("random_gap", gap);
            if (w != 399) accept(d, pe, pt);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] bits;
      int          n;
      build_frame(8'h3C, 1'b1, 1'b0, bits, n);
      accept(8'h3C, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) begin
         if (i > 0) tick();
         expect_line("midframe", i, bits[i], 1'b1);
         // Noise on all inputs while the frame is running.
         p_data     = 8'($urandom);
         par_en     = 1'($urandom);
         par_typ    = 1'($urandom);
         data_valid = ((i / 2) % 2) == 0;
      end
      // Stop-bit cycle: present the next word.
      accept(8'h5A, 1'b0, 1'b1);
      check_frame("back_to_back", 8'h5A, 1'b0, 1'b1);
      idle_cycles("back_to_back_idle", 3);
   endtask

   task automatic test_reset_midframe();
      accept(8'hFF, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) tick(); // now showing data bit 4
      expect_line("pre_reset_bit4", 5, 1'b1, 1'b1);
      rst = 1'b1;
      tick();
      expect_line("reset_midframe", 0, 1'b1, 1'b0);
      rst = 1'b0;
      data_valid = 1'b0;
      idle_cycles("post_reset_idle", 20);
   endtask

   initial begin
      rst = 1'b1; data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0;
      #1;
      test_reset();
      test_idle();
      test_no_parity();
      test_parity();
      test_random();
      test_back_to_back();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
